// File: rtl/sqrt_seq_pkg.sv
// Shared definitions for the sequential square-root block: FSM state encoding
// and the derived widths of root, remainder, trial difference and iteration counter.
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int root_w(input int w);
    return w / 2;
  endfunction

  function automatic int rem_w(input int w);
    return w / 2 + 1;
  endfunction

  function automatic int trial_w(input int w);
    return w / 2 + 3;
  endfunction

  function automatic int cnt_w(input int w);
    return $clog2(w / 2);
  endfunction

endpackage

// File: rtl/sqrt_seq_if.sv
// Valid/ready bundle between the radicand producer, the square-root block and
// the result consumer.
interface sqrt_seq_if #(
  parameter int W = 16
);

  logic             i_valid;
  logic             i_ready;
  logic [W-1:0]     i;
  logic             rnd;
  logic             o_valid;
  logic             o_ready;
  logic [W/2-1:0]   o;
  logic [W/2:0]     r;
  logic             sat;

  modport master (
    output i_valid, i, rnd, o_ready,
    input  i_ready, o_valid, o, r, sat
  );

  modport slave (
    input  i_valid, i, rnd, o_ready,
    output i_ready, o_valid, o, r, sat
  );

endinterface

// File: rtl/sqrt_seq_step.sv
// One restoring digit-recurrence step: consumes one radicand bit pair and
// produces the next partial remainder and one more root bit.
module sqrt_step
  import sqrt_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [rem_w(W)-1:0]  rem,
  input  logic [root_w(W)-1:0] root,
  input  logic [1:0]           pair,
  output logic [rem_w(W)-1:0]  next_rem,
  output logic [root_w(W)-1:0] next_root
);

  localparam int RTW = root_w(W);
  localparam int RMW = rem_w(W);
  localparam int TW  = trial_w(W);

  logic [TW-1:0] ext;
  logic [TW-1:0] sub;
  logic          fits;

  // Comparing both operands unsigned is the same as testing the trial
  // difference for a non-negative sign, and when it fits the true difference
  // always lands inside the remainder width, so the low bits suffice.
  always_comb begin
    ext       = {rem, pair};
    sub       = {1'b0, root, 2'b01};
    fits      = (ext >= sub);
    next_rem  = fits ? (ext[RMW-1:0] - sub[RMW-1:0]) : ext[RMW-1:0];
    next_root = {root[RTW-2:0], fits};
  end

endmodule

// File: rtl/sqrt_seq.sv
// Iterative integer square root: one root bit per clock through a single
// shared step, with optional round-to-nearest and valid/ready on both sides.
module sqrt_seq
  import sqrt_pkg::*;
#(
  parameter int W = 16
) (
  input  logic       clk,
  input  logic       rst,
  sqrt_seq_if.slave  bus
);

  localparam int RTW = root_w(W);
  localparam int RMW = rem_w(W);
  localparam int CW  = cnt_w(W);
  localparam logic [CW-1:0] LAST = CW'(RTW - 1);

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   rad;
  logic           mode;
  logic [RTW-1:0] root;
  logic [RMW-1:0] rem;
  logic [CW-1:0]  cnt;
  logic [RTW-1:0] o_q;
  logic [RMW-1:0] r_q;
  logic           sat_q;
  logic           ready_c;
  logic           valid_c;
  logic [RMW-1:0] step_rem;
  logic [RTW-1:0] step_root;
  logic           round_up;
  logic           root_full;

  sqrt_step #(.W(W)) u_step (
    .rem       (rem),
    .root      (root),
    .pair      (rad[W-1 -: 2]),
    .next_rem  (step_rem),
    .next_root (step_root)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    valid_c   = 1'b0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.i_valid) state_nxt = CALC;
      end
      CALC: begin
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        valid_c = 1'b1;
        if (bus.o_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // rem > root after the last step is exactly sqrt(I) >= root + 0.5.
  always_comb begin
    round_up  = mode && ({1'b0, step_root} < step_rem);
    root_full = &step_root;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rad   <= '0;
      mode  <= 1'b0;
      root  <= '0;
      rem   <= '0;
      cnt   <= '0;
      o_q   <= '0;
      r_q   <= '0;
      sat_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_valid) begin
            rad  <= bus.i;
            mode <= bus.rnd;
            root <= '0;
            rem  <= '0;
            cnt  <= LAST;
          end
        end
        CALC: begin
          rad  <= {rad[W-3:0], 2'b00};
          root <= step_root;
          rem  <= step_rem;
          cnt  <= cnt - CW'(1);
          if (cnt == '0) begin
            r_q   <= step_rem;
            sat_q <= round_up && root_full;
            o_q   <= (round_up && !root_full) ? (step_root + RTW'(1)) : step_root;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.i_ready = ready_c;
  assign bus.o_valid = valid_c;
  assign bus.o       = o_q;
  assign bus.r       = r_q;
  assign bus.sat     = sat_q;

endmodule

// File: tb/tb_sqrt_seq.sv
// Self-checking bench for sqrt_seq: W=8 vector table and corner sequences,
// then a W=16 sweep against a reference model with random consumer stalls.
module tb_sqrt_seq;

  typedef struct {
    int unsigned i;
    bit          rnd;
    int unsigned o;
    int unsigned r;
    bit          sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   hs8 = 0;
  int   hs16 = 0;
  bit   rand16 = 1'b0;
  exp_t q8[$];
  exp_t q16[$];
  exp_t e8;
  exp_t e16;
  exp_t tbl[12];

  sqrt_seq_if #(.W(8))  if8 ();
  sqrt_seq_if #(.W(16)) if16 ();

  sqrt_seq #(.W(8))  dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
  sqrt_seq #(.W(16)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Independent reference: floor root by search, round-up when I > k*k + k.
  function automatic exp_t model16(input int unsigned x, input bit rnd);
    exp_t e;
    int unsigned k;
    k = 0;
    while ((k + 1) * (k + 1) <= x) k++;
    e.i   = x;
    e.rnd = rnd;
    e.o   = k;
    e.r   = x - k * k;
    e.sat = 1'b0;
    if (rnd && (x > k * k + k)) begin
      if (k == 255) e.sat = 1'b1;
      else          e.o   = k + 1;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && if8.o_valid && if8.o_ready) begin
      hs8++;
      if (q8.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL w8 unexpected result: got o=%0d r=%0d, required none", if8.o, if8.r);
      end else begin
        e8 = q8.pop_front();
        checkOutput($sformatf("w8 root i=%0d rnd=%0d", e8.i, e8.rnd), if8.o, e8.o);
        checkOutput($sformatf("w8 rem i=%0d rnd=%0d", e8.i, e8.rnd), if8.r, e8.r);
        checkOutput($sformatf("w8 sat i=%0d rnd=%0d", e8.i, e8.rnd), if8.sat, e8.sat);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && if16.o_valid && if16.o_ready) begin
      hs16++;
      if (q16.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL w16 unexpected result: got o=%0d r=%0d, required none", if16.o, if16.r);
      end else begin
        e16 = q16.pop_front();
        checkOutput($sformatf("w16 root i=%0d rnd=%0d", e16.i, e16.rnd), if16.o, e16.o);
        checkOutput($sformatf("w16 rem i=%0d rnd=%0d", e16.i, e16.rnd), if16.r, e16.r);
        checkOutput($sformatf("w16 sat i=%0d rnd=%0d", e16.i, e16.rnd), if16.sat, e16.sat);
        if (!e16.rnd)
          checkOutput($sformatf("w16 o*o+r i=%0d", e16.i),
                      32'(if16.o) * 32'(if16.o) + 32'(if16.r), e16.i);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand16) if16.o_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus8(input int unsigned x, input bit rnd, input bit push,
                                input int unsigned eo, input int unsigned er, input bit es,
                                input bit chkLat);
    int n;
    exp_t e;
    @(posedge clk);
    #1;
    n = 0;
    while (!if8.i_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!if8.i_ready) begin
      tests++;
      fails++;
      $display("[TB] FAIL w8 accept timeout i=%0d: got i_ready=0, required 1", x);
      return;
    end
    if8.i       = x[7:0];
    if8.rnd     = rnd;
    if8.i_valid = 1'b1;
    if (push) begin
      e.i = x; e.rnd = rnd; e.o = eo; e.r = er; e.sat = es;
      q8.push_back(e);
    end
    @(posedge clk);
    #1;
    if8.i_valid = 1'b0;
    if (chkLat) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!if8.o_valid && n < 40);
      checkOutput($sformatf("w8 latency i=%0d", x), n, 5);
      checkOutput("w8 i_ready while o_valid", if8.i_ready, 0);
      if (if8.o_ready) begin
        @(negedge clk);
        checkOutput("w8 i_ready after handshake", if8.i_ready, 1);
        checkOutput("w8 o_valid after handshake", if8.o_valid, 0);
      end
    end
  endtask

  task automatic applyStimulus16(input int unsigned x, input bit rnd);
    int n;
    @(posedge clk);
    #1;
    n = 0;
    while (!if16.i_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!if16.i_ready) begin
      tests++;
      fails++;
      $display("[TB] FAIL w16 accept timeout i=%0d: got i_ready=0, required 1", x);
      return;
    end
    if16.i       = x[15:0];
    if16.rnd     = rnd;
    if16.i_valid = 1'b1;
    q16.push_back(model16(x, rnd));
    @(posedge clk);
    #1;
    if16.i_valid = 1'b0;
  endtask

  initial begin
    int n;
    int hsBefore;
    int unsigned x;

    tbl[0]  = '{200, 1'b0, 14, 4,  1'b0};
    tbl[1]  = '{210, 1'b1, 14, 14, 1'b0};
    tbl[2]  = '{211, 1'b1, 15, 15, 1'b0};
    tbl[3]  = '{255, 1'b1, 15, 30, 1'b1};
    tbl[4]  = '{255, 1'b0, 15, 30, 1'b0};
    tbl[5]  = '{0,   1'b0, 0,  0,  1'b0};
    tbl[6]  = '{0,   1'b1, 0,  0,  1'b0};
    tbl[7]  = '{1,   1'b1, 1,  0,  1'b0};
    tbl[8]  = '{3,   1'b1, 2,  2,  1'b0};
    tbl[9]  = '{224, 1'b1, 15, 28, 1'b0};
    tbl[10] = '{143, 1'b1, 12, 22, 1'b0};
    tbl[11] = '{16,  1'b0, 4,  0,  1'b0};

    rst = 1'b1;
    if8.i_valid  = 1'b0; if8.i  = '0; if8.rnd  = 1'b0; if8.o_ready  = 1'b1;
    if16.i_valid = 1'b0; if16.i = '0; if16.rnd = 1'b0; if16.o_ready = 1'b1;

    @(posedge clk);
    @(negedge clk);
    checkOutput("reset w8 i_ready", if8.i_ready, 1);
    checkOutput("reset w8 o_valid", if8.o_valid, 0);
    checkOutput("reset w8 o", if8.o, 0);
    checkOutput("reset w8 r", if8.r, 0);
    checkOutput("reset w8 sat", if8.sat, 0);
    checkOutput("reset w16 i_ready", if16.i_ready, 1);
    checkOutput("reset w16 o_valid", if16.o_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int k = 0; k < 12; k++)
      applyStimulus8(tbl[k].i, tbl[k].rnd, 1'b1, tbl[k].o, tbl[k].r, tbl[k].sat, 1'b1);

    // Consumer stall with input noise while the result is held.
    @(posedge clk);
    #1;
    if8.o_ready = 1'b0;
    applyStimulus8(144, 1'b0, 1'b1, 12, 0, 1'b0, 1'b0);
    n = 0;
    while (!if8.o_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("w8 stall result arrives", if8.o_valid, 1);
    hsBefore = hs8;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if8.i_valid = ~if8.i_valid;
      if8.i       = 8'd99;
      @(negedge clk);
      checkOutput("w8 stall o_valid", if8.o_valid, 1);
      checkOutput("w8 stall o", if8.o, 12);
      checkOutput("w8 stall r", if8.r, 0);
      checkOutput("w8 stall sat", if8.sat, 0);
      checkOutput("w8 stall i_ready", if8.i_ready, 0);
    end
    @(posedge clk);
    #1;
    if8.i_valid = 1'b0;
    if8.o_ready = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("w8 handshakes after release", hs8 - hsBefore, 1);
    checkOutput("w8 idle after release", if8.i_ready, 1);
    checkOutput("w8 o_valid after release", if8.o_valid, 0);
    checkOutput("w8 o held after handshake", if8.o, 12);
    checkOutput("w8 queue after release", q8.size(), 0);

    // Abort in the second CALC cycle, then a fresh operation.
    applyStimulus8(200, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("w8 abort i_ready", if8.i_ready, 1);
    checkOutput("w8 abort o_valid", if8.o_valid, 0);
    checkOutput("w8 abort o", if8.o, 0);
    checkOutput("w8 abort r", if8.r, 0);
    checkOutput("w8 abort sat", if8.sat, 0);
    applyStimulus8(49, 1'b0, 1'b1, 7, 0, 1'b0, 1'b1);
    checkOutput("w8 queue at end", q8.size(), 0);

    // W=16 sweep with random consumer backpressure.
    rand16 = 1'b1;
    applyStimulus16(0, 1'b0);     applyStimulus16(0, 1'b1);
    applyStimulus16(1, 1'b0);     applyStimulus16(1, 1'b1);
    applyStimulus16(65535, 1'b0); applyStimulus16(65535, 1'b1);
    for (int k = 1; k < 256; k++) begin
      for (int m = 0; m < 2; m++) begin
        applyStimulus16(k * k - 1, m[0]);
        applyStimulus16(k * k, m[0]);
        applyStimulus16(k * k + k, m[0]);
        applyStimulus16(k * k + k + 1, m[0]);
      end
    end
    for (int k = 0; k < 1000; k++) begin
      x = $urandom_range(0, 65535);
      applyStimulus16(x, 1'($urandom_range(0, 1)));
    end
    @(posedge clk);
    #1;
    rand16 = 1'b0;
    if16.o_ready = 1'b1;
    n = 0;
    while (q16.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("w16 queue drained", q16.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sqrt_seq.md
Name: sqrt_seq

Overview:
- Parametrised, iterative, restoring digit-by-digit integer square root.
- Produces one root bit per clock and reports the remainder.
- Selectable per operation: truncate (floor) or round-to-nearest.
- Sits between producer and consumer stages behind valid/ready handshakes on input and output. Replaces fixed-width combinational square-root arrays where area matters more than latency.

Parameters:
- W, 16, radicand width in bits; must be even and ≥ 4. Root width is W/2; remainder width is W/2+1.

Ports:
- CLK  in  1  clock, rising-edge.
- RST  in  1  reset, synchronous, active-high.
- I_VALID  in  1  radicand valid.
- I_READY  out  1  block can accept a radicand.
- I  in  W  unsigned radicand.
- RND  in  1  mode, sampled with I: 0 = floor, 1 = round to nearest.
- O_VALID  out  1  result valid.
- O_READY  in  1  consumer accepts result.
- O  out  W/2  root.
- R  out  W/2+1  remainder, I − floor_root², in both modes.
- SAT  out  1  rounded root saturated.

Behaviour:
- Reset values (on the first CLK edge with RST=1): state IDLE, I_READY=1, O_VALID=0, O=0, R=0, SAT=0, all internal registers 0.
- RST mid-operation aborts the operation. Any in-flight or unconsumed result is discarded.
- State IDLE:
  - I_READY=1.
  - On I_VALID & I_READY in cycle t: latch I and RND, clear root and remainder, set iteration counter to W/2−1, go to CALC.
- State CALC:
  - I_READY=0; I_VALID is ignored.
  - Each cycle, take the next two radicand bits, MSB pair first.
  - trial = {rem, pair} − {root, 2'b01}, computed at W/2+3 bits.
  - If trial ≥ 0: rem = trial, root = {root, 1}.
  - Else: rem = {rem, pair}, root = {root, 0}.
  - After the iteration with counter 0, go to DONE.
  - CALC occupies exactly W/2 cycles, t+1 through t+W/2.
- Entry to DONE (registered at the end of the last CALC cycle):
  - O_VALID=1 from cycle t+W/2+1.
  - R = final rem.
  - RND=0: O = root, SAT=0.
  - RND=1 and rem > root: the rounded result is root+1. If root is all ones, O = all ones and SAT=1; otherwise O = root+1 and SAT=0.
  - RND=1 and rem ≤ root: O = root, SAT=0.
  - Rationale: rem > root is exactly the condition sqrt(I) ≥ root+0.5 for integer I.
- State DONE:
  - I_READY=0.
  - O, R, SAT and O_VALID are held stable while O_READY=0 (no drop, no change).
  - On O_VALID & O_READY: O_VALID falls next cycle, go to IDLE. I_READY rises in that same next cycle.
  - O, R, SAT keep their last values after the handshake.
- Throughput: one operation per W/2+2 cycles when O_READY is held high.
- Invariants: remainder never exceeds 2*root. R fits in W/2+1 bits with no truncation.
- I=0: O=0, R=0. Timing is the same as any other value (no early exit).
- A change on I or RND while not in IDLE has no effect.

Decomposition:
- Shared package sqrt_pkg:
  - State encoding constants IDLE=2'd0, CALC=2'd1, DONE=2'd2.
  - Derived-width helpers for root (W/2), remainder (W/2+1) and trial (W/2+3).
  - Counter width, clog2(W/2).
- Sub-module sqrt_step, combinational and parametrised by W:
  - Inputs: rem, root, pair.
  - Outputs: next_rem, next_root.
  - The FSM instantiates it once and iterates it over time.
  - It is also reusable for unrolled or pipelined variants.

Test Plan:
- W=8, I=200, RND=0, O_READY=1: I accepted cycle t; O_VALID at t+5 with O=14, R=4, SAT=0; I_READY high at t+6.
- W=8, I=210 RND=1 → O=14, R=14 (rem = root, no round-up). Then I=211 RND=1 → O=15, R=15.
- W=8, I=255, RND=1 → O=15, R=30, SAT=1. Same I with RND=0 → O=15, SAT=0. I=0 → O=0, R=0 after the same 5-cycle latency.
- Backpressure: W=8, I=144, O_READY=0 for 10 cycles → O=12, R=0 held stable and I_READY=0 throughout, with I_VALID toggled and I changed to 99 during the stall. Release O_READY → exactly one handshake, then IDLE.
- RST asserted in the 2nd CALC cycle → next cycle I_READY=1, O_VALID=0, O=0, R=0. A fresh I=49 then yields O=7, R=0.
- W=16 random sweep of 1000 radicands plus the values 0, 1, 65535 and the square boundaries k²−1, k², k²+k, k²+k+1, both modes, randomised O_READY. Required: O²+R = I under RND=0; rounded O matches the floor-of-sqrt(I)+0.5 model, saturated to 255 with SAT=1 at the top.
